tile_fb_write_ctrl: RTL and testbench

- Write-side controller for the 32x24 tile framebuffer (768 entries, 8-bit colour) that the graphics driver reads via tile address = (vc/20)*32 + (hc/20).
- Schedules framebuffer writes between two requesters: single-tile writes from game logic, and a built-in fill sequencer that paints every tile one colour.
- Optionally restricts all writes to vertical blanking so visible frames never tear.
- Drives the framebuffer write port (wr_en/wr_addr/wr_data).

---
 rtl/tile_fb_write_ctrl_pkg.sv | 14 +
 rtl/tile_fill_seq.sv | 53 +++++
 rtl/tile_fb_write_ctrl.sv | 72 +++++++
 tb/tb_tile_fb_write_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tile_fb_write_ctrl_pkg.sv
// tile_fb_write_ctrl_pkg: tile framebuffer geometry, colours and fill FSM states.
// The graphics driver imports this package too.
package tile_fb_write_ctrl_pkg;
    localparam int HTILES = 32;
    localparam int VTILES = 24;
    localparam int ADDR_W = 10;
    localparam int COLOR_W = 8;
    localparam logic [ADDR_W-1:0] NUM_TILES = ADDR_W'(HTILES * VTILES);
    localparam logic [ADDR_W-1:0] LAST_TILE = NUM_TILES - 1'b1;
    localparam logic [9:0] VIS_LINES = 10'd480;
    localparam logic [COLOR_W-1:0] BLK = 8'h00;
    localparam logic [COLOR_W-1:0] WHT = 8'hff;
    typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;
endpackage

// File: rtl/tile_fill_seq.sv
// tile_fill_seq: full-screen fill sequencer; walks tiles 0..NUM_TILES-1 with a latched colour.
module tile_fill_seq
    import tile_fb_write_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               fill_start,
    input  logic [COLOR_W-1:0] fill_color,
    input  logic               grant,
    output logic               fill_req,
    output logic [ADDR_W-1:0]  fill_addr,
    output logic [COLOR_W-1:0] fill_data,
    output logic               fill_busy,
    output logic               fill_done
);
    fill_state_t state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [COLOR_W-1:0] color_q, color_d;
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        color_d = color_q;
        case (state_q)
            IDLE: if (fill_start) begin
                state_d = FILL;
                ptr_d = '0;
                color_d = fill_color;
            end
            // ptr parks on the last tile rather than stepping past the framebuffer
            FILL: if (grant) begin
                state_d = (ptr_q == LAST_TILE) ? DONE : FILL;
                ptr_d = (ptr_q == LAST_TILE) ? ptr_q : ptr_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            color_q <= color_d;
        end
    end
    assign fill_req = (state_q == FILL);
    assign fill_busy = (state_q == FILL);
    assign fill_done = (state_q == DONE);
    assign fill_addr = ptr_q;
    assign fill_data = color_q;
endmodule

// File: rtl/tile_fb_write_ctrl.sv
// tile_fb_write_ctrl: arbitrates game-logic single writes against the fill sequencer
// onto one registered framebuffer write port, optionally only during vertical blanking.
module tile_fb_write_ctrl
    import tile_fb_write_ctrl_pkg::*;
#(
    parameter bit BLANK_ONLY = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         vc,
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [COLOR_W-1:0] req_color,
    output logic               req_ready,
    input  logic               fill_start,
    input  logic [COLOR_W-1:0] fill_color,
    output logic               fill_busy,
    output logic               fill_done,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               addr_err
);
    logic write_ok, hs, addr_bad, single_wr, fill_req, fill_grant;
    logic [ADDR_W-1:0] fill_addr;
    logic [COLOR_W-1:0] fill_data;
    logic wr_en_q, wr_en_d, addr_err_q, addr_err_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [COLOR_W-1:0] wr_data_q, wr_data_d;
    tile_fill_seq u_fill_seq (
        .clk        (clk),
        .rst        (rst),
        .fill_start (fill_start),
        .fill_color (fill_color),
        .grant      (fill_grant),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );
    // A handshake always blocks the fill that cycle, even when the address is dropped.
    always_comb begin
        write_ok = !BLANK_ONLY || (vc >= VIS_LINES);
        req_ready = write_ok && !rst;
        hs = req_valid && req_ready;
        addr_bad = (req_addr >= NUM_TILES);
        single_wr = hs && !addr_bad;
        fill_grant = fill_req && write_ok && !hs;
        wr_en_d = single_wr || fill_grant;
        wr_addr_d = single_wr ? req_addr : fill_grant ? fill_addr : wr_addr_q;
        wr_data_d = single_wr ? req_color : fill_grant ? fill_data : wr_data_q;
        addr_err_d = hs && addr_bad;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            wr_en_q <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            addr_err_q <= addr_err_d;
        end
    end
    assign wr_en = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign addr_err = addr_err_q;
endmodule

// File: tb/tb_tile_fb_write_ctrl.sv
// tb_tile_fb_write_ctrl: directed stimulus with a write scoreboard for tile_fb_write_ctrl.
module tb_tile_fb_write_ctrl;
    import tile_fb_write_ctrl_pkg::*;
    typedef struct packed {
        logic [ADDR_W-1:0]  a;
        logic [COLOR_W-1:0] d;
    } wr_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [9:0] vc = '0;
    logic req_valid = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [COLOR_W-1:0] req_color = '0;
    logic fill_start = 1'b0;
    logic [COLOR_W-1:0] fill_color = '0;
    logic req_ready, fill_busy, fill_done, wr_en, addr_err;
    logic [ADDR_W-1:0] wr_addr;
    logic [COLOR_W-1:0] wr_data;
    int vectors = 0;
    int errors = 0;
    int writes_seen = 0;
    int done_cnt = 0;
    int base, dcnt;
    wr_t sb[$];

    always #5 clk = ~clk;

    tile_fb_write_ctrl #(.BLANK_ONLY(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .vc         (vc),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_color  (req_color),
        .req_ready  (req_ready),
        .fill_start (fill_start),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .addr_err   (addr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic push_fill(input int from, input int to, input logic [COLOR_W-1:0] c);
        for (int i = from; i <= to; i++) sb.push_back({ADDR_W'(i), c});
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 2000 && done_cnt < target; i++) cyc();
        chk("fill_done_count", 32'(done_cnt), 32'(target));
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (wr_en) begin
            writes_seen++;
            vectors++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed addr %0d data %0h expected no write", wr_addr, wr_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.a));
                chk("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
        if (fill_done) begin
            done_cnt++;
            chk("done_with_last_write", 32'({wr_en, wr_addr}), 32'({1'b1, LAST_TILE}));
        end
    end

    initial begin
        vc = 10'd500;
        cyc(2);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_fill_busy", 32'(fill_busy), 32'd0);
        chk("rst_fill_done", 32'(fill_done), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        rst = 1'b0;
        req_valid = 1'b1;
        req_addr = 10'd15;
        req_color = WHT;
        sb.push_back({10'd15, WHT});
        #1 chk("blank_ready", 32'(req_ready), 32'd1);
        base = writes_seen;
        cyc();
        req_valid = 1'b0;
        chk("single_latency", 32'(writes_seen), 32'(base + 1));
        chk("single_wr_en", 32'(wr_en), 32'd1);
        cyc();
        chk("strobe_width", 32'(wr_en), 32'd0);
        chk("hold_addr", 32'(wr_addr), 32'd15);
        chk("hold_data", 32'(wr_data), 32'hff);

        vc = 10'd100;
        req_valid = 1'b1;
        req_addr = 10'd20;
        req_color = 8'h3c;
        #1 chk("visible_ready", 32'(req_ready), 32'd0);
        base = writes_seen;
        cyc(3);
        chk("visible_no_write", 32'(writes_seen), 32'(base));
        chk("visible_wr_en", 32'(wr_en), 32'd0);
        vc = 10'd480;
        sb.push_back({10'd20, 8'h3c});
        #1 chk("edge_ready", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        chk("edge_latency", 32'(writes_seen), 32'(base + 1));

        vc = 10'd500;
        req_valid = 1'b1;
        req_addr = 10'd800;
        req_color = 8'h11;
        #1 chk("bad_ready", 32'(req_ready), 32'd1);
        base = writes_seen;
        cyc();
        req_valid = 1'b0;
        chk("addr_err_set", 32'(addr_err), 32'd1);
        chk("bad_wr_en", 32'(wr_en), 32'd0);
        chk("bad_hold_addr", 32'(wr_addr), 32'd20);
        chk("bad_hold_data", 32'(wr_data), 32'h3c);
        cyc();
        chk("addr_err_pulse", 32'(addr_err), 32'd0);
        chk("bad_no_write", 32'(writes_seen), 32'(base));

        fill_start = 1'b1;
        fill_color = BLK;
        push_fill(0, 99, BLK);
        cyc();
        fill_start = 1'b0;
        chk("fill_busy_start", 32'(fill_busy), 32'd1);
        cyc(50);
        fill_start = 1'b1;
        fill_color = 8'haa;
        cyc();
        fill_start = 1'b0;
        cyc(49);
        req_valid = 1'b1;
        req_addr = 10'd5;
        req_color = WHT;
        sb.push_back({10'd5, WHT});
        push_fill(100, 767, BLK);
        cyc();
        req_valid = 1'b0;
        chk("contention_busy", 32'(fill_busy), 32'd1);
        wait_done(1);
        cyc();
        chk("done_pulse_width", 32'(fill_done), 32'd0);
        chk("busy_after_done", 32'(fill_busy), 32'd0);
        chk("idle_wr_en", 32'(wr_en), 32'd0);

        fill_start = 1'b1;
        fill_color = WHT;
        push_fill(0, 767, WHT);
        cyc();
        fill_start = 1'b0;
        cyc(300);
        vc = 10'd100;
        base = writes_seen;
        cyc(5);
        chk("pause_no_write", 32'(writes_seen), 32'(base));
        chk("pause_busy", 32'(fill_busy), 32'd1);
        chk("pause_ready", 32'(req_ready), 32'd0);
        vc = 10'd500;
        wait_done(2);
        cyc();

        fill_start = 1'b1;
        fill_color = 8'h77;
        push_fill(0, 49, 8'h77);
        cyc();
        fill_start = 1'b0;
        cyc(50);
        rst = 1'b1;
        #1 chk("rst_mid_ready", 32'(req_ready), 32'd0);
        base = writes_seen;
        dcnt = done_cnt;
        cyc();
        chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
        chk("rst_mid_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_mid_wr_data", 32'(wr_data), 32'd0);
        chk("rst_mid_busy", 32'(fill_busy), 32'd0);
        chk("rst_mid_done", 32'(fill_done), 32'd0);
        chk("rst_mid_addr_err", 32'(addr_err), 32'd0);
        rst = 1'b0;
        cyc(3);
        chk("rst_no_write", 32'(writes_seen), 32'(base));
        chk("rst_no_done", 32'(done_cnt), 32'(dcnt));
        fill_start = 1'b1;
        fill_color = 8'h42;
        push_fill(0, 767, 8'h42);
        cyc();
        fill_start = 1'b0;
        wait_done(3);
        cyc();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
